cpu_memory_array: RTL and testbench

CPU_MEMORY_ARRAY -- requirements
Module: cpu_memory_array

---
 rtl/cpu_memory_array.sv | 154 +++++++++++++++
 tb/tb_cpu_memory_array.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_memory_array.sv
// cpu_memory_array
//   Word-addressed memory array with one byte-maskable write port and
//   RD_CHANNELS independent read channels. Each read channel runs a small
//   IDLE/WAIT/DONE FSM. It returns data RD_LATENCY cycles after the request
//   and marks it with a one-cycle done pulse.
//
//   Optional feature: define CPU_MEM_WR_BYPASS_EN to make a read sampled at
//   the same edge as a write to the same word return the merged new bytes
//   (write-first). Without the macro, reads at that edge see the old word
//   (read-before-write).
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous, active-high; clears read channels, not the array
//   mem_wr_en    : byte write enables (bit0 = low byte, bit1 = high byte)
//   mem_wr_addr  : write word address
//   mem_wr_data  : write data
//   mem_rd_en    : per-channel read request level
//   mem_rd_addr  : per-channel read word address
//   mem_rd_done  : per-channel one-cycle pulse, read data valid
//   mem_rd_data  : per-channel read data, held until the next done
module cpu_memory_array #(
  parameter  int MEM_DEPTH   = 32768,
  parameter  int WORD_SIZE   = 16,
  parameter  int RD_CHANNELS = 2,
  parameter  int RD_LATENCY  = 2,
  localparam int ADDR_W      = $clog2(MEM_DEPTH-1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mem_wr_en,
  input  logic [ADDR_W-1:0]      mem_wr_addr,
  input  logic [WORD_SIZE-1:0]   mem_wr_data,
  input  logic [RD_CHANNELS-1:0] mem_rd_en,
  input  logic [ADDR_W-1:0]      mem_rd_addr [RD_CHANNELS],
  output logic [RD_CHANNELS-1:0] mem_rd_done,
  output logic [WORD_SIZE-1:0]   mem_rd_data [RD_CHANNELS]
);

  localparam int         BYTE_W   = WORD_SIZE / 2;
  localparam logic [3:0] LOAD_CNT = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } rd_state_e;

  logic [WORD_SIZE-1:0] mem_array [MEM_DEPTH];

  // Replace only the enabled bytes of old_w with those of new_w.
  function automatic logic [WORD_SIZE-1:0] merge_bytes(
    input logic [WORD_SIZE-1:0] old_w,
    input logic [WORD_SIZE-1:0] new_w,
    input logic [1:0]           be
  );
    merge_bytes = {be[1] ? new_w[WORD_SIZE-1:BYTE_W] : old_w[WORD_SIZE-1:BYTE_W],
                   be[0] ? new_w[BYTE_W-1:0]         : old_w[BYTE_W-1:0]};
  endfunction

  // Byte-masked array write; writes during reset are dropped and the
  // array itself is never cleared.
  always_ff @(posedge clk) begin
    if (!reset && (mem_wr_en != 2'b00)) begin
      mem_array[mem_wr_addr] <= merge_bytes(mem_array[mem_wr_addr], mem_wr_data, mem_wr_en);
    end
  end

  for (genvar c = 0; c < RD_CHANNELS; c++) begin : g_ch
    rd_state_e            state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic [ADDR_W-1:0]    samp_addr_s;
    logic [WORD_SIZE-1:0] samp_word_s;

    // In WAIT the latched address is sampled. Otherwise the only possible
    // sampling is a latency-1 accept, which uses the incoming address.
    always_comb begin
      samp_addr_s = (state_q == ST_WAIT) ? addr_q : mem_rd_addr[c];
    end

    // Word seen at the sampling edge. The array read reflects writes from
    // earlier edges only, unless the write-first bypass is built in.
    always_comb begin
      samp_word_s = mem_array[samp_addr_s];
`ifdef CPU_MEM_WR_BYPASS_EN
      if (!reset && (samp_addr_s == mem_wr_addr)) begin
        samp_word_s = merge_bytes(mem_array[samp_addr_s], mem_wr_data, mem_wr_en);
      end else begin
        samp_word_s = mem_array[samp_addr_s];
      end
`endif
    end

    // Read channel next-state: accept in IDLE/DONE, count down in WAIT,
    // sample the array on the edge that enters DONE.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (mem_rd_en[c]) begin
            addr_d = mem_rd_addr[c];
            cnt_d  = LOAD_CNT;
            if (LOAD_CNT == 4'd0) begin
              state_d = ST_DONE;
              data_d  = samp_word_s;
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          // Requests and address changes during WAIT are ignored.
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_DONE;
            data_d  = samp_word_s;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end

    // Read channel registers with synchronous reset that aborts any read.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= 4'd0;
        addr_q  <= {ADDR_W{1'b0}};
        data_q  <= {WORD_SIZE{1'b0}};
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        addr_q  <= addr_d;
        data_q  <= data_d;
      end
    end

    assign mem_rd_done[c] = (state_q == ST_DONE);
    assign mem_rd_data[c] = data_q;
  end

endmodule

// File: tb/tb_cpu_memory_array.sv
module tb_cpu_memory_array;

  localparam int AW = 15;

  logic        clk;
  logic        reset;
  logic [1:0]  wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  rd_en;
  logic [AW-1:0] rd_addr [2];
  logic [1:0]  done_l2, done_l1;
  logic [15:0] data_l2 [2];
  logic [15:0] data_l1 [2];

  cpu_memory_array #(.RD_LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset), .mem_wr_en(wr_en), .mem_wr_addr(wr_addr),
    .mem_wr_data(wr_data), .mem_rd_en(rd_en), .mem_rd_addr(rd_addr),
    .mem_rd_done(done_l2), .mem_rd_data(data_l2));

  cpu_memory_array #(.RD_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .mem_wr_en(wr_en), .mem_wr_addr(wr_addr),
    .mem_wr_data(wr_data), .mem_rd_en(rd_en), .mem_rd_addr(rd_addr),
    .mem_rd_done(done_l1), .mem_rd_data(data_l1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: timestamp-based. A read accepted at edge k completes
  // at edge k+L-1 and samples the memory contents as they were before that
  // edge's write (or merged with it when the bypass is built in).
  logic [15:0] model_mem [32768];
  int          edge_no = 0;
  int          due     [2][2];
  logic [AW-1:0] paddr [2][2];
  logic        exp_done [2][2];
  logic [15:0] exp_data [2][2];
  logic [15:0] pre_val [16];

  function automatic logic [15:0] model_sample(input logic [AW-1:0] a);
    logic [15:0] w;
    w = model_mem[a];
`ifdef CPU_MEM_WR_BYPASS_EN
    if (a == wr_addr) begin
      if (wr_en[0]) w[7:0]  = wr_data[7:0];
      if (wr_en[1]) w[15:8] = wr_data[15:8];
    end
`endif
    return w;
  endfunction

  task automatic model_edge();
    for (int inst = 0; inst < 2; inst++) begin
      int lat;
      lat = (inst == 0) ? 2 : 1;
      for (int c = 0; c < 2; c++) begin
        if (reset) begin
          due[inst][c]      = -1;
          exp_done[inst][c] = 1'b0;
          exp_data[inst][c] = 16'h0000;
        end else begin
          exp_done[inst][c] = 1'b0;
          if (rd_en[c] && (due[inst][c] < edge_no)) begin
            due[inst][c]   = edge_no + lat - 1;
            paddr[inst][c] = rd_addr[c];
          end
          if (due[inst][c] == edge_no) begin
            exp_done[inst][c] = 1'b1;
            exp_data[inst][c] = model_sample(paddr[inst][c]);
          end
        end
      end
    end
    if (!reset) begin
      if (wr_en[0]) model_mem[wr_addr][7:0]  = wr_data[7:0];
      if (wr_en[1]) model_mem[wr_addr][15:8] = wr_data[15:8];
    end
    edge_no++;
  endtask

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // One clock: advance the model, take the edge, compare away from it.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("model_done_l2_ch%0d", c), {15'd0, done_l2[c]}, {15'd0, exp_done[0][c]});
      check($sformatf("model_data_l2_ch%0d", c), data_l2[c], exp_data[0][c]);
      check($sformatf("model_done_l1_ch%0d", c), {15'd0, done_l1[c]}, {15'd0, exp_done[1][c]});
      check($sformatf("model_data_l1_ch%0d", c), data_l1[c], exp_data[1][c]);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; wr_en = 2'b00; wr_addr = '0; wr_data = 16'h0000;
    rd_en = 2'b00; rd_addr[0] = '0; rd_addr[1] = '0;
  endtask

  typedef struct {
    logic          rst;
    logic [1:0]    wen;
    logic [AW-1:0] waddr;
    logic [15:0]   wdata;
    logic [1:0]    ren;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [1:0]    edone;
    logic [15:0]   ed0;
    logic [15:0]   ed1;
  } vec_t;

  vec_t tbl [23];

`ifdef CPU_MEM_WR_BYPASS_EN
  localparam logic [15:0] E_COLL = 16'hFFFF;
`else
  localparam logic [15:0] E_COLL = 16'h0000;
`endif

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) begin
        due[i][c] = -1; paddr[i][c] = '0; exp_done[i][c] = 1'b0; exp_data[i][c] = 16'h0000;
      end
    end
    // Expected values are for the latency-2 instance after each row's edge.
    //          rst   wen    waddr  wdata     ren    ra0    ra1    edone  ed0       ed1
    tbl[0]  = '{1'b0, 2'b11, 15'd5, 16'h1234, 2'b00, 15'd0, 15'd0, 2'b00, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b01, 15'd5, 15'd0, 2'b00, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b00, 15'd0, 15'd0, 2'b01, 16'h1234, 16'h0000};
    tbl[3]  = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b00, 15'd0, 15'd0, 2'b00, 16'h1234, 16'h0000};
    tbl[4]  = '{1'b0, 2'b01, 15'd5, 16'hAB56, 2'b00, 15'd0, 15'd0, 2'b00, 16'h1234, 16'h0000};
    tbl[5]  = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b01, 15'd5, 15'd0, 2'b00, 16'h1234, 16'h0000};
    tbl[6]  = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b00, 15'd0, 15'd0, 2'b01, 16'h1256, 16'h0000};
    tbl[7]  = '{1'b0, 2'b11, 15'd7, 16'hBEEF, 2'b00, 15'd0, 15'd0, 2'b00, 16'h1256, 16'h0000};
    tbl[8]  = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b11, 15'd7, 15'd7, 2'b00, 16'h1256, 16'h0000};
    tbl[9]  = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b01, 15'd5, 15'd0, 2'b11, 16'hBEEF, 16'hBEEF};
    tbl[10] = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b00, 15'd0, 15'd0, 2'b00, 16'hBEEF, 16'hBEEF};
    tbl[11] = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b01, 15'd9, 15'd0, 2'b00, 16'hBEEF, 16'hBEEF};
    tbl[12] = '{1'b0, 2'b11, 15'd9, 16'hFFFF, 2'b00, 15'd0, 15'd0, 2'b01, E_COLL,   16'hBEEF};
    tbl[13] = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b00, 15'd0, 15'd0, 2'b00, E_COLL,   16'hBEEF};
    tbl[14] = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b01, 15'd9, 15'd0, 2'b00, E_COLL,   16'hBEEF};
    tbl[15] = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b00, 15'd0, 15'd0, 2'b01, 16'hFFFF, 16'hBEEF};
    tbl[16] = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b01, 15'd5, 15'd0, 2'b00, 16'hFFFF, 16'hBEEF};
    tbl[17] = '{1'b1, 2'b11, 15'd7, 16'h0000, 2'b00, 15'd0, 15'd0, 2'b00, 16'h0000, 16'h0000};
    tbl[18] = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b00, 15'd0, 15'd0, 2'b00, 16'h0000, 16'h0000};
    tbl[19] = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b01, 15'd7, 15'd0, 2'b00, 16'h0000, 16'h0000};
    tbl[20] = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b00, 15'd0, 15'd0, 2'b01, 16'hBEEF, 16'h0000};
    tbl[21] = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b10, 15'd0, 15'd5, 2'b00, 16'hBEEF, 16'h0000};
    tbl[22] = '{1'b0, 2'b00, 15'd0, 16'h0000, 2'b00, 15'd0, 15'd0, 2'b10, 16'hBEEF, 16'h1256};

    // Reset and check the reset state of both instances.
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    check("reset_done_l2", {14'd0, done_l2}, 16'h0000);
    check("reset_data_l2_ch0", data_l2[0], 16'h0000);
    check("reset_data_l1_ch1", data_l1[1], 16'h0000);

    // Preload words 0..15; word 9 is deliberately zero.
    for (int a = 0; a < 16; a++) begin
      idle_inputs();
      pre_val[a] = (a == 9) ? 16'h0000 : 16'($urandom);
      wr_en = 2'b11; wr_addr = AW'(a); wr_data = pre_val[a];
      cycle();
    end

    // Directed table.
    for (int i = 0; i < 23; i++) begin
      reset = tbl[i].rst; wr_en = tbl[i].wen; wr_addr = tbl[i].waddr; wr_data = tbl[i].wdata;
      rd_en = tbl[i].ren; rd_addr[0] = tbl[i].ra0; rd_addr[1] = tbl[i].ra1;
      cycle();
      check($sformatf("tbl%0d_done", i), {14'd0, done_l2}, {14'd0, tbl[i].edone});
      check($sformatf("tbl%0d_data0", i), data_l2[0], tbl[i].ed0);
      check($sformatf("tbl%0d_data1", i), data_l2[1], tbl[i].ed1);
    end

    // Latency 1: channel 1 held high for three requests, done every cycle.
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      rd_en = 2'b10; rd_addr[1] = AW'(k);
      cycle();
      check($sformatf("lat1_b2b%0d_done", k), {15'd0, done_l1[1]}, 16'h0001);
      check($sformatf("lat1_b2b%0d_data", k), data_l1[1], pre_val[k]);
    end
    idle_inputs();
    cycle();
    check("lat1_b2b_end_done", {15'd0, done_l1[1]}, 16'h0000);
    check("lat1_b2b_end_hold", data_l1[1], pre_val[2]);

    // Randomized traffic on words 0..15 against the reference model.
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 59) == 0);
      wr_en      = 2'($urandom_range(0, 3));
      wr_addr    = AW'($urandom_range(0, 15));
      wr_data    = 16'($urandom);
      rd_en      = 2'($urandom_range(0, 3));
      rd_addr[0] = AW'($urandom_range(0, 15));
      rd_addr[1] = AW'($urandom_range(0, 15));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
